vdp_hdmi_frame_lock: RTL and testbench

VDP_HDMI_FRAME_LOCK -- requirements
Module: vdp_hdmi_frame_lock

---
 rtl/vdp_hdmi_frame_lock.sv | 155 +++++++++++++++
 tb/tb_vdp_hdmi_frame_lock.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp_hdmi_frame_lock.sv
// Locks HDMI raster timing to the VDP raster: measures the VDP frame and fires a timed video_reset.
// Define VDP_HDMI_SYNC_STATS_EN to implement the frame_period / resync_count statistics registers.
module vdp_hdmi_frame_lock #(
    parameter int unsigned CX_W       = 12,
    parameter int unsigned CY_W       = 11,
    parameter int unsigned CNT_W      = 28,
    parameter int unsigned LEAD       = 1,
    parameter int unsigned MISS_LIMIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [10:0]      vdp_cx,
    input  logic [10:0]      vdp_cy,
    input  logic [CX_W-1:0]  hdmi_cx,
    input  logic [CY_W-1:0]  hdmi_cy,
    output logic             video_reset,
    output logic             locked,
    output logic             lock_lost,
    output logic [CNT_W-1:0] frame_period,
    output logic [7:0]       resync_count
);

    localparam logic [1:0] S_LOCKED      = 2'd0;
    localparam logic [1:0] S_WAIT_ORIGIN = 2'd1;
    localparam logic [1:0] S_MEASURE     = 2'd2;
    localparam logic [1:0] S_COUNTDOWN   = 2'd3;

    localparam int unsigned       MISS_W    = $clog2(MISS_LIMIT + 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_LIMIT - 1);
    localparam logic [CNT_W-1:0]  LEAD_P1   = CNT_W'(LEAD + 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [1:0]        r_state;
    logic [MISS_W-1:0] r_miss;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_video_reset;
    logic              r_locked;
    logic              r_lock_lost;

    logic w_match;
    logic w_origin;
    logic w_latch;
    logic w_fire;

    // Both sides widened to a common width so any CX_W/CY_W compares as zero-extended values.
    assign w_match  = ({{CX_W{1'b0}}, vdp_cx} == {11'd0, hdmi_cx}) &&
                      ({{CY_W{1'b0}}, vdp_cy} == {11'd0, hdmi_cy});
    assign w_origin = (vdp_cx == 11'd0) && (vdp_cy == 11'd0);
    assign w_latch  = !w_match && (r_state == S_MEASURE) && w_origin && (r_cnt > LEAD_P1);
    assign w_fire   = !w_match && (r_state == S_COUNTDOWN) && (r_cnt == CNT_ONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_WAIT_ORIGIN;
            r_miss        <= '0;
            r_cnt         <= '0;
            r_video_reset <= 1'b1;
            r_locked      <= 1'b0;
            r_lock_lost   <= 1'b0;
        end else begin
            r_video_reset <= w_fire;
            r_lock_lost   <= 1'b0;
            if (w_match) begin
                r_state  <= S_LOCKED;
                r_miss   <= '0;
                r_cnt    <= '0;
                r_locked <= 1'b1;
            end else begin
                case (r_state)
                    S_LOCKED: begin
                        r_cnt <= '0;
                        if (r_miss == MISS_LAST) begin
                            r_state     <= S_WAIT_ORIGIN;
                            r_miss      <= '0;
                            r_locked    <= 1'b0;
                            r_lock_lost <= 1'b1;
                        end else begin
                            r_miss <= r_miss + 1'b1;
                        end
                    end
                    S_WAIT_ORIGIN: begin
                        if (w_origin) begin
                            r_state <= S_MEASURE;
                            r_cnt   <= CNT_ONE;
                        end else begin
                            r_cnt <= '0;
                        end
                    end
                    S_MEASURE: begin
                        if (w_origin) begin
                            // A too-short frame restarts the measurement from this origin.
                            if (w_latch) begin
                                r_state <= S_COUNTDOWN;
                                r_cnt   <= r_cnt - LEAD_P1;
                            end else begin
                                r_cnt <= CNT_ONE;
                            end
                        end else if (r_cnt == CNT_MAX) begin
                            r_state <= S_WAIT_ORIGIN;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                    S_COUNTDOWN: begin
                        // Pulse is registered, so firing at count 1 lands P-LEAD cycles after origin.
                        if (w_fire) begin
                            r_state  <= S_LOCKED;
                            r_miss   <= '0;
                            r_cnt    <= '0;
                            r_locked <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - CNT_ONE;
                        end
                    end
                    default: begin
                        r_state <= S_WAIT_ORIGIN;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign video_reset = r_video_reset;
    assign locked      = r_locked;
    assign lock_lost   = r_lock_lost;

`ifdef VDP_HDMI_SYNC_STATS_EN
    logic [CNT_W-1:0] r_frame_period;
    logic [7:0]       r_resync_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_period <= '0;
            r_resync_count <= '0;
        end else begin
            if (w_latch) begin
                r_frame_period <= r_cnt;
            end
            if (w_fire && (r_resync_count != 8'hff)) begin
                r_resync_count <= r_resync_count + 8'd1;
            end
        end
    end

    assign frame_period = r_frame_period;
    assign resync_count = r_resync_count;
`else
    assign frame_period = '0;
    assign resync_count = '0;
`endif

endmodule

// File: tb/tb_vdp_hdmi_frame_lock.sv
// Self-checking bench for vdp_hdmi_frame_lock: raster generators, an HDMI sink that obeys
// video_reset, and a timestamp-based reference model of the lock/resync rules.
module tb_vdp_hdmi_frame_lock;

    localparam int CX_W       = 12;
    localparam int CY_W       = 11;
    localparam int CNT_W      = 28;
    localparam int LEAD       = 1;
    localparam int MISS_LIMIT = 4;

`ifdef VDP_HDMI_SYNC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam int ST_LOCKED = 0;
    localparam int ST_WAIT   = 1;
    localparam int ST_MEAS   = 2;
    localparam int ST_CD     = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [10:0]      vdp_cx = '0;
    logic [10:0]      vdp_cy = '0;
    logic [CX_W-1:0]  hdmi_cx = '0;
    logic [CY_W-1:0]  hdmi_cy = '0;
    logic             video_reset;
    logic             locked;
    logic             lock_lost;
    logic [CNT_W-1:0] frame_period;
    logic [7:0]       resync_count;

    always #5 clk = ~clk;

    vdp_hdmi_frame_lock #(
        .CX_W      (CX_W),
        .CY_W      (CY_W),
        .CNT_W     (CNT_W),
        .LEAD      (LEAD),
        .MISS_LIMIT(MISS_LIMIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .vdp_cx      (vdp_cx),
        .vdp_cy      (vdp_cy),
        .hdmi_cx     (hdmi_cx),
        .hdmi_cy     (hdmi_cy),
        .video_reset (video_reset),
        .locked      (locked),
        .lock_lost   (lock_lost),
        .frame_period(frame_period),
        .resync_count(resync_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Environment state
    int    fw = 10, fh = 4;
    int    vx = 0, vy = 0, hx = 0, hy = 0;
    int    glitch_left = 0;
    bit    force_match = 1'b0;
    bit    sink_en = 1'b0;
    longint cyc = 0;

    // Reference model state; expected outputs are for the cycle currently visible
    int     m_state, m_miss, m_rc;
    longint m_start, m_fire_at, m_fp;
    logic   e_vr, e_locked, e_ll;
    logic [CNT_W-1:0] e_fp;
    int     e_rc;

    task automatic model_reset();
        m_state = ST_WAIT; m_miss = 0; m_rc = 0; m_fp = 0; m_start = 0; m_fire_at = 0;
        e_vr = 1'b1; e_locked = 1'b0; e_ll = 1'b0; e_fp = '0; e_rc = 0;
    endtask

    task automatic model_step();
        bit     match, origin;
        longint p;
        match  = (int'(vdp_cx) == int'(hdmi_cx)) && (int'(vdp_cy) == int'(hdmi_cy));
        origin = (vdp_cx == 0) && (vdp_cy == 0);
        e_vr = 1'b0;
        e_ll = 1'b0;
        if (match) begin
            m_state = ST_LOCKED;
            m_miss  = 0;
        end else begin
            case (m_state)
                ST_LOCKED: begin
                    m_miss++;
                    if (m_miss >= MISS_LIMIT) begin
                        m_state = ST_WAIT; m_miss = 0; e_ll = 1'b1;
                    end
                end
                ST_WAIT: if (origin) begin m_state = ST_MEAS; m_start = cyc; end
                ST_MEAS: begin
                    p = cyc - m_start;
                    if (origin) begin
                        if (p <= LEAD + 1) m_start = cyc;
                        else begin
                            m_state = ST_CD; m_fp = p; m_fire_at = cyc + p - LEAD;
                        end
                    end else if (p >= (longint'(1) << CNT_W) - 1) begin
                        m_state = ST_WAIT;
                    end
                end
                default: begin
                    if (cyc + 1 == m_fire_at) begin
                        e_vr = 1'b1; m_state = ST_LOCKED; m_miss = 0;
                        if (m_rc < 255) m_rc++;
                    end
                end
            endcase
        end
        e_locked = (m_state == ST_LOCKED);
        e_fp = STATS ? CNT_W'(m_fp) : '0;
        e_rc = STATS ? m_rc : 0;
    endtask

    task automatic drive();
        if (force_match) begin hx = vx; hy = vy; end
        vdp_cx  = 11'(vx);
        vdp_cy  = 11'(vy);
        hdmi_cx = CX_W'(hx);
        hdmi_cy = CY_W'(hy);
        // Bit 11 is never set by the VDP, so this guarantees a mismatch
        if (glitch_left > 0) hdmi_cx = CX_W'(hx) ^ CX_W'(12'h800);
    endtask

    task automatic set_offset(input int k);
        int idx;
        idx = (vy * fw + vx + k) % (fw * fh);
        hx = idx % fw;
        hy = idx / fw;
    endtask

    task automatic tick();
        bit sink_rst;
        sink_rst = (video_reset === 1'b1) && sink_en;
        @(posedge clk);
        #1;
        if (!reset) model_step();
        cyc++;
        vx++;
        if (vx >= fw) begin vx = 0; vy++; if (vy >= fh) vy = 0; end
        if (sink_rst) begin
            hx = 0; hy = 0;
        end else begin
            hx++;
            if (hx >= fw) begin hx = 0; hy++; if (hy >= fh) hy = 0; end
        end
        if (glitch_left > 0) glitch_left--;
        drive();
    endtask

    task automatic test_reset();
        #2;
        reset = 1'b1; sink_en = 1'b0; model_reset();
        fw = 10; fh = 4; vx = 0; vy = 0; hx = 0; hy = 0;
        glitch_left = 0; force_match = 1'b0;
        drive();
        repeat (3) tick();
        n_checks++; if (video_reset !== 1'b1) begin n_fail++; $display("FAIL reset_video_reset got=%b exp=1", video_reset); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got=%b exp=0", locked); end
        n_checks++; if (lock_lost !== 1'b0) begin n_fail++; $display("FAIL reset_lock_lost got=%b exp=0", lock_lost); end
        n_checks++; if (frame_period !== '0) begin n_fail++; $display("FAIL reset_frame_period got=%0d exp=0", frame_period); end
        n_checks++; if (resync_count !== 8'd0) begin n_fail++; $display("FAIL reset_resync_count got=%0d exp=0", resync_count); end
        reset = 1'b0;
        tick();
        sink_en = 1'b1;
        n_checks++; if (video_reset !== 1'b0) begin n_fail++; $display("FAIL release_video_reset got=%b exp=0", video_reset); end
    endtask

    task automatic test_identical();
        for (int i = 0; i < 100; i++) begin
            n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL ident_locked i=%0d got=%b exp=1", i, locked); end
            n_checks++; if (video_reset !== 1'b0) begin n_fail++; $display("FAIL ident_video_reset i=%0d got=%b exp=0", i, video_reset); end
            tick();
        end
        n_checks++; if (resync_count !== 8'd0) begin n_fail++; $display("FAIL ident_resync_count got=%0d exp=0", resync_count); end
    endtask

    task automatic test_glitch();
        bit seen = 1'b0;
        glitch_left = MISS_LIMIT - 1;
        drive();
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL glitch3_locked i=%0d got=%b exp=1", i, locked); end
            n_checks++; if (lock_lost !== 1'b0) begin n_fail++; $display("FAIL glitch3_lock_lost i=%0d got=%b exp=0", i, lock_lost); end
        end
        glitch_left = MISS_LIMIT;
        drive();
        for (int i = 0; i < 8; i++) begin
            tick();
            if (lock_lost === 1'b1) seen = 1'b1;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL glitch4_lock_lost got=0 exp=1"); end
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL glitch4_relock got=%b exp=1", locked); end
    endtask

    task automatic test_offset_resync();
        int     n = 0;
        int     origins = 0;
        longint second_origin = -1;
        longint pulse_cyc = -1;
        set_offset(7);
        drive();
        for (int i = 1; i <= 20 && n == 0; i++) begin
            tick();
            if (lock_lost === 1'b1) n = i;
        end
        n_checks++; if (n != MISS_LIMIT) begin n_fail++; $display("FAIL offs_lock_lost_delay got=%0d exp=%0d", n, MISS_LIMIT); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL offs_unlocked got=%b exp=0", locked); end
        for (int i = 0; i < 200 && pulse_cyc < 0; i++) begin
            if (vdp_cx == 0 && vdp_cy == 0) begin
                origins++;
                if (origins == 2) second_origin = cyc;
            end
            tick();
            if (i == 0) begin
                n_checks++; if (lock_lost !== 1'b0) begin n_fail++; $display("FAIL offs_lock_lost_width got=%b exp=0", lock_lost); end
            end
            if (video_reset === 1'b1) pulse_cyc = cyc;
        end
        n_checks++;
        if (pulse_cyc < 0 || second_origin < 0 || pulse_cyc - second_origin != 39) begin
            n_fail++;
            $display("FAIL offs_pulse_delay got=%0d exp=39", pulse_cyc - second_origin);
        end
        n_checks++; if (frame_period !== (STATS ? CNT_W'(40) : '0)) begin n_fail++; $display("FAIL offs_frame_period got=%0d exp=%0d", frame_period, STATS ? 40 : 0); end
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL offs_locked_at_pulse got=%b exp=1", locked); end
        tick();
        n_checks++; if (video_reset !== 1'b0) begin n_fail++; $display("FAIL offs_pulse_width got=%b exp=0", video_reset); end
        n_checks++; if (hdmi_cx != CX_W'(vdp_cx) || hdmi_cy != CY_W'(vdp_cy)) begin n_fail++; $display("FAIL offs_hdmi_aligned got=%0d,%0d exp=%0d,%0d", hdmi_cx, hdmi_cy, vdp_cx, vdp_cy); end
        repeat (5) tick();
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL offs_stays_locked got=%b exp=1", locked); end
        n_checks++; if (resync_count !== (STATS ? 8'd1 : 8'd0)) begin n_fail++; $display("FAIL offs_resync_count got=%0d exp=%0d", resync_count, STATS ? 1 : 0); end
    endtask

    task automatic test_match_abort();
        int rc_before = m_rc;
        int k = 0;
        set_offset(13);
        drive();
        while (m_state != ST_CD && k < 300) begin tick(); k++; end
        n_checks++; if (m_state != ST_CD) begin n_fail++; $display("FAIL abort_reach_countdown got=%0d exp=%0d", m_state, ST_CD); end
        repeat (5) tick();
        force_match = 1'b1;
        drive();
        for (int i = 0; i < 60; i++) begin
            tick();
            n_checks++; if (video_reset !== 1'b0) begin n_fail++; $display("FAIL abort_no_pulse i=%0d got=%b exp=0", i, video_reset); end
        end
        force_match = 1'b0;
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL abort_locked got=%b exp=1", locked); end
        n_checks++; if (resync_count !== 8'(STATS ? rc_before : 0)) begin n_fail++; $display("FAIL abort_resync_count got=%0d exp=%0d", resync_count, STATS ? rc_before : 0); end
    endtask

    task automatic test_reset_mid_countdown();
        int k = 0;
        set_offset(5);
        drive();
        while (m_state != ST_CD && k < 300) begin tick(); k++; end
        n_checks++; if (m_state != ST_CD) begin n_fail++; $display("FAIL rstcd_reach_countdown got=%0d exp=%0d", m_state, ST_CD); end
        repeat (5) tick();
        reset = 1'b1; sink_en = 1'b0; model_reset();
        #1;
        n_checks++; if (video_reset !== 1'b1) begin n_fail++; $display("FAIL rstcd_video_reset_async got=%b exp=1", video_reset); end
        repeat (3) tick();
        n_checks++; if (video_reset !== 1'b1) begin n_fail++; $display("FAIL rstcd_video_reset_held got=%b exp=1", video_reset); end
        reset = 1'b0;
        tick();
        sink_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            n_checks++; if (video_reset !== 1'b0) begin n_fail++; $display("FAIL rstcd_no_pending i=%0d got=%b exp=0", i, video_reset); end
            n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rstcd_unlocked i=%0d got=%b exp=0", i, locked); end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            tick();
            n_checks++; if (video_reset !== e_vr) begin n_fail++; $display("FAIL rnd_video_reset cyc=%0d got=%b exp=%b", cyc, video_reset, e_vr); end
            n_checks++; if (locked !== e_locked) begin n_fail++; $display("FAIL rnd_locked cyc=%0d got=%b exp=%b", cyc, locked, e_locked); end
            n_checks++; if (lock_lost !== e_ll) begin n_fail++; $display("FAIL rnd_lock_lost cyc=%0d got=%b exp=%b", cyc, lock_lost, e_ll); end
            n_checks++; if (frame_period !== e_fp) begin n_fail++; $display("FAIL rnd_frame_period cyc=%0d got=%0d exp=%0d", cyc, frame_period, e_fp); end
            n_checks++; if (resync_count !== 8'(e_rc)) begin n_fail++; $display("FAIL rnd_resync_count cyc=%0d got=%0d exp=%0d", cyc, resync_count, e_rc); end
            force_match = 1'b0;
            if (reset) begin
                if ($urandom_range(0, 2) == 0) reset = 1'b0;
                continue;
            end
            if (!sink_en) sink_en = 1'b1;
            if ($urandom_range(0, 999) == 0) begin
                reset = 1'b1; sink_en = 1'b0; model_reset();
            end else if ($urandom_range(0, 399) == 0) begin
                fw = $urandom_range(2, 12); fh = $urandom_range(1, 5);
                vx = 0; vy = 0;
                set_offset($urandom_range(0, fw * fh - 1));
                drive();
            end else if ($urandom_range(0, 99) == 0) begin
                set_offset($urandom_range(1, fw * fh - 1));
                drive();
            end else if ($urandom_range(0, 79) == 0) begin
                glitch_left = $urandom_range(1, 6);
                drive();
            end else if ($urandom_range(0, 199) == 0) begin
                force_match = 1'b1;
                drive();
            end
        end
    endtask

    initial begin
        test_reset();
        test_identical();
        test_glitch();
        test_offset_resync();
        test_match_abort();
        test_reset_mid_countdown();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
